// File: rtl/fp2int_convert_sched.sv
// fp2int_convert_sched: a float32 to int32 converter shared by NREQ requesters.
// A round-robin arbiter grants one request at a time. An iterative shifter
// aligns the mantissa one bit per cycle, truncating toward zero. The result
// returns with the requester ID and the {invalid, overflow, inexact} flags.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. On the request side, req_ready is a combinational one-hot grant,
// offered only in IDLE. On the response side, resp_valid and the resp_*
// payload hold stable until the edge where resp_ready is also 1.
module fp2int_convert_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic [2:0]        resp_flags,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_SIGN = 2'd2, S_RESP = 2'd3} state_t;

  state_t           r_state, w_next;
  logic [IDW-1:0]   r_rr_ptr, r_id, r_resp_id;
  logic [31:0]      r_mag, r_resp_data;
  logic [4:0]       r_cnt;
  logic             r_left, r_sticky, r_special, r_sign, r_resp_valid;
  logic [2:0]       r_flags, r_resp_flags;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_found, w_accept;
  logic [31:0]      w_op, w_dec_mag;
  logic [7:0]       w_exp;
  logic [4:0]       w_dec_cnt;
  logic             w_dec_left, w_dec_special;
  logic [2:0]       w_dec_flags;

  // Round-robin search upward from r_rr_ptr with wrap-around; grant only in IDLE
  always_comb begin
    int idx;
    idx      = 0;
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'(idx);
      end
    end
    if (r_state == S_IDLE && w_found) w_grant[w_gnt_id] = 1'b1;
  end

  assign req_ready = w_grant;
  assign w_accept  = |(req_valid & req_ready);
  assign w_op      = req_data[32*int'(w_gnt_id) +: 32];
  assign w_exp     = w_op[30:23];

  // Decode the granted operand into a starting magnitude and a shift plan.
  // Special operands load their final value and skip shifting.
  always_comb begin
    w_dec_mag     = {8'd0, 1'b1, w_op[22:0]};
    w_dec_cnt     = 5'd0;
    w_dec_left    = 1'b0;
    w_dec_special = 1'b1;
    w_dec_flags   = 3'b000;
    if (w_exp == 8'd255) begin
      w_dec_mag   = (w_op[22:0] != 23'd0 || !w_op[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      w_dec_flags = (w_op[22:0] != 23'd0) ? 3'b100 : 3'b010;
    end else if (w_exp >= 8'd158 && w_op != 32'hCF00_0000) begin
      w_dec_mag   = w_op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      w_dec_flags = 3'b010;
    end else if (w_exp == 8'd0) begin
      w_dec_mag   = 32'd0;
      w_dec_flags = {2'b00, (w_op[22:0] != 23'd0)};
    end else if (w_exp <= 8'd126) begin
      w_dec_mag   = 32'd0;
      w_dec_flags = 3'b001;
    end else begin
      // Unbiased exponent 0..30, or exactly -2^31 (exponent 31, mantissa 0)
      w_dec_special = 1'b0;
      if (w_exp < 8'd150) begin
        w_dec_cnt = 5'(8'd150 - w_exp);
      end else begin
        w_dec_cnt  = 5'(w_exp - 8'd150);
        w_dec_left = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: CALC lasts max(N,1) cycles, SIGN one, RESP until accepted
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: if (r_cnt <= 5'd1) w_next = S_SIGN;
      S_SIGN: w_next = S_RESP;
      S_RESP: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch on accept, shift in CALC, negate in SIGN, hold in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_mag        <= '0;
      r_cnt        <= '0;
      r_left       <= 1'b0;
      r_sticky     <= 1'b0;
      r_special    <= 1'b0;
      r_sign       <= 1'b0;
      r_flags      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_resp_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_mag     <= w_dec_mag;
          r_cnt     <= w_dec_cnt;
          r_left    <= w_dec_left;
          r_special <= w_dec_special;
          r_sign    <= w_op[31];
          r_sticky  <= 1'b0;
          r_flags   <= w_dec_flags;
          r_id      <= w_gnt_id;
          r_rr_ptr  <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
        S_CALC: if (r_cnt != 5'd0) begin
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag    <= r_mag >> 1;
            r_sticky <= r_sticky | r_mag[0];
          end
          r_cnt <= r_cnt - 5'd1;
        end
        S_SIGN: begin
          r_resp_data  <= (r_sign && !r_special) ? (~r_mag + 32'd1) : r_mag;
          r_resp_flags <= r_special ? r_flags : {2'b00, r_sticky};
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
        end
        S_RESP: if (resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign resp_flags = r_resp_flags;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fp2int_convert_sched.sv
// Bench for fp2int_convert_sched: directed vectors, round-robin order,
// backpressure hold, async reset mid-job and random operands checked against
// an arithmetic reference model.
module tb_fp2int_convert_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 3 + IDW + 32;

  logic               clk, rst_n;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*32-1:0] req_data;
  logic               resp_valid, resp_ready, busy;
  logic [31:0]        resp_data;
  logic [IDW-1:0]     resp_id;
  logic [2:0]         resp_flags;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  fp2int_convert_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_flags(resp_flags),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: value = 1.M * 2^e, truncated toward zero, in plain integer arithmetic
  function automatic void ref_model(input logic [31:0] a, output logic [31:0] res,
                                    output logic [2:0] fl, output int lat);
    int     ex, e, n;
    longint mag, v;
    logic   s;
    s   = a[31];
    ex  = int'(a[30:23]);
    e   = ex - 127;
    mag = longint'(a[22:0]) + (64'sd1 << 23);
    fl  = 3'b000;
    lat = 3;
    res = 32'd0;
    if (ex == 255 && a[22:0] != 0) begin
      res = 32'h7FFF_FFFF; fl = 3'b100;
    end else if (ex == 255 || (e >= 31 && a != 32'hCF00_0000)) begin
      res = s ? 32'h8000_0000 : 32'h7FFF_FFFF; fl = 3'b010;
    end else if (ex == 0) begin
      fl = {2'b00, a[22:0] != 0};
    end else if (e < 0) begin
      fl = 3'b001;
    end else begin
      if (e >= 23) begin
        n = e - 23;
        v = mag * (64'sd1 << n);
      end else begin
        n = 23 - e;
        v = mag / (64'sd1 << n);
        fl[0] = (v * (64'sd1 << n)) != mag;
      end
      if (s) v = -v;
      res = v[31:0];
      lat = ((n > 1) ? n : 1) + 2;
    end
  endfunction

  // Driver: call #1 after a rising edge with the DUT idle. Offers the request,
  // checks the grant, accepts it, then scrambles the operand bus.
  task automatic issue(input int id, input logic [31:0] a, input logic [NREQ-1:0] extra);
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    ref_model(a, r, f, l);
    exp_q.push_back({f, IDW'(id), r});
    lat_q.push_back(l);
    req_valid = extra | NREQ'(1 << id);
    req_data[32*id +: 32] = a;
    @(negedge clk);
    check("grant", 64'(req_ready), 64'(1 << id));
    @(posedge clk); #1;
    req_valid = '0;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Scoreboard side: counts edges (accept edge = 1) until resp_valid, checks payload and handshake
  task automatic collect();
    int edges, hold;
    logic [W-1:0] exp;
    int lat;
    edges = 1;
    while (!resp_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    check("latency", 64'(edges), 64'(lat));
    check("resp", 64'({resp_flags, resp_id, resp_data}), 64'(exp));
    check("busy_resp", 64'(busy), 64'd1);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk); #1;
      check("held", 64'({resp_valid, resp_flags, resp_id, resp_data}), 64'({1'b1, exp}));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_drop", 64'({resp_valid, busy}), 64'd0);
  endtask

  task automatic run_one(input int id, input logic [31:0] a);
    issue(id, a, '0);
    collect();
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] a;
    int sel;
    a   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 7)       a[30:23] = 8'($urandom_range(120, 160));
    else if (sel == 7) a[30:23] = 8'd0;
    else if (sel == 8) a[30:23] = 8'd255;
    else               a = $urandom_range(0, 1) ? 32'hCF00_0000 : 32'h4F00_0000;
    return a;
  endfunction

  initial begin
    int gnt[$];
    logic [W-1:0] snap;
    int cyc;
    logic [31:0] vec [8];
    vec = '{32'h3F80_0000, 32'hC2F6_E979, 32'h4F00_0000, 32'hCF00_0000,
            32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h3F00_0000};

    rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 64'({resp_valid, resp_data, resp_id, resp_flags, busy, req_ready}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin order with all requesters asserting, responses accepted at once
    req_valid = '1; req_data = '0; resp_ready = 1'b1;
    cyc = 0;
    while (gnt.size() < 5 && cyc < 60) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt.push_back(i);
      if (gnt.size() == 5) resp_ready = 1'b0;
      cyc++;
    end
    check("rr_count", 64'(gnt.size()), 64'd5);
    for (int i = 0; i < gnt.size(); i++) check("rr_order", 64'(gnt[i]), 64'(i % NREQ));

    // Backpressure: response and all outputs stay put while resp_ready is low
    cyc = 0;
    while (!resp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("bp_valid", 64'(resp_valid), 64'd1);
    snap = {resp_flags, resp_id, resp_data};
    check("bp_payload", 64'(snap), 64'({3'b000, 2'd0, 32'd0}));
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold", 64'({resp_valid, busy, req_ready, resp_flags, resp_id, resp_data}),
            64'({1'b1, 1'b1, 4'b0000, snap}));
    end
    req_valid = '0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Directed vectors, rotating through requesters
    for (int i = 0; i < 8; i++) run_one((i == 1) ? 2 : i % NREQ, vec[i]);

    // Random operands from random requesters
    for (int i = 0; i < 40; i++) run_one($urandom_range(0, NREQ - 1), rand_float());

    // Async reset mid-CALC: leave a nonzero result on resp_data first, then start a long job on requester 1
    run_one(3, 32'hC2F6_E979);
    issue(1, 32'h3F80_0000, '0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", 64'({resp_valid, resp_data, resp_id, resp_flags, busy, req_ready}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 32'h4040_0000, 4'b0100);
    collect();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp2int_convert_sched.md
Name: fp2int_convert_sched

Overview:
Shared, multi-cycle IEEE-754 single-precision to signed 32-bit integer conversion engine, time-shared between NREQ requesters. A round-robin arbiter grants one request at a time. An iterative shifter sequences the conversion at one bit per cycle. The result is returned with the requester ID and exception flags over a valid/ready response channel. It sits between the FPU issue logic and the integer writeback path.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), requester ID width (derived; minimum 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_data  in  NREQ*32  per-requester float operand; requester i uses bits [32i+31:32i]
req_ready  out  NREQ  one-hot grant; request i is accepted on an edge where req_valid[i] and req_ready[i] are both 1
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts the result
resp_data  out  32  signed integer result, truncated toward zero
resp_id  out  IDW  index of the requester that owns resp_data
resp_flags  out  3  {invalid, overflow, inexact}
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, resp_valid=0, resp_data=0, resp_id=0, resp_flags=0, busy=0. Reset clears any conversion in flight; the result is lost and no response is issued.
- States: IDLE -> CALC -> SIGN -> RESP -> IDLE.
- IDLE arbitration:
  - req_ready is combinational and asserted only in IDLE.
  - It is one-hot on the first req_valid bit found searching upward from rr_ptr, with wrap-around.
  - All zeros when no request is valid.
- On accept: latch the operand and ID, set rr_ptr=(granted+1) mod NREQ, go to CALC.
- Decode: s=A[31], E=A[30:23], M=A[22:0], e=E-127 (signed), mag={1,M} zero-extended to 32 bits.
- Special cases. Each loads the final value directly with N=0; no mag shifting occurs, so CALC lasts 1 idle cycle.
  - E=255, M!=0 (NaN): result 0x7FFFFFFF, invalid=1.
  - E=255, M=0 (Inf): +Inf gives 0x7FFFFFFF, -Inf gives 0x80000000; overflow=1.
  - e>=31, except exactly 0xCF000000: saturate as for Inf; overflow=1.
  - E=0 (zero or denormal): result 0; inexact=(M!=0).
  - 1<=E<=126 (e<0): result 0; inexact=1.
- Normal path, 0<=e<=30 or A=0xCF000000:
  - If e<23: N=23-e right shifts; each bit shifted out ORs into sticky.
  - If e>=23: N=e-23 left shifts.
  - One shift per CALC cycle, counting N down to 0. CALC occupies max(N,1) cycles.
  - inexact=sticky.
- SIGN (1 cycle): if s=1 and the operand is not special, mag=(~mag)+1. For 0xCF000000, the 2's complement of 0x80000000 gives 0x80000000 with no flag.
- Latency: resp_valid rises max(N,1)+2 edges after the accept edge.
- RESP:
  - resp_valid=1; resp_data, resp_id and resp_flags are held stable until resp_valid&resp_ready.
  - On that edge: resp_valid=0, go to IDLE.
  - No grant is issued while in RESP (backpressure).
  - New arbitration starts in the following IDLE cycle, giving a minimum of 1 IDLE cycle between jobs.
- req_data changing after acceptance has no effect.
- A requester dropping req_valid in IDLE before being granted is legal; it is not granted.

Test Plan:
- req_valid=0001, data 0x3F800000 (1.0) -> accept; resp_valid rises 25 edges later (N=23); resp_data=0x00000001, id=0, flags=000.
- req2 = 0xC2F6E979 (-123.456) -> N=17, response after 19 edges; resp_data=0xFFFFFF85, id=2, flags=001.
- 0x4F000000 -> 0x7FFFFFFF, flags=010, latency 3; 0xCF000000 -> 0x80000000, flags=000, N=8, latency 10; 0xFF800000 -> 0x80000000, flags=010.
- 0x7FC00000 -> 0x7FFFFFFF, flags=100; 0x80000000 (-0.0) -> 0, flags=000; 0x3F000000 (0.5) -> 0, flags=001; all with latency 3.
- req_valid=1111 held with resp_ready=1 -> grant order 0,1,2,3,0. Then hold resp_ready=0 for 10 cycles: resp_* stays stable, req_ready=0000, busy=1.
- Assert rst_n=0 mid-CALC -> all outputs go to 0 immediately; after release with req_valid=0110, the first grant is 1 (rr_ptr=0).
